// File: rtl/sprite_pkg.sv
// ---------------------------------------------------------------------------
// sprite_pkg
// Shared definitions for the sprite renderer: screen geometry, the animation
// FSM state type and the frame/row/column to ROM address mapping.
// ---------------------------------------------------------------------------
package sprite_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [0:0] {
        PLAY      = 1'b0,
        HOLD_LAST = 1'b1
    } anim_state_t;

    // Frames are stored back-to-back, each one row-major.
    function automatic int unsigned sprite_addr(
        input int unsigned frame,
        input int unsigned row,
        input int unsigned col,
        input int unsigned spr_w = 16,
        input int unsigned spr_h = 16
    );
        return frame * spr_w * spr_h + row * spr_w + col;
    endfunction

endpackage

// File: rtl/sprite_anim_ctrl.sv
// ---------------------------------------------------------------------------
// sprite_anim_ctrl
// Shadow latch for position/flip and the animation frame sequencer.
//   i_frame_tick        : once per video frame; the only time shadows load
//   i_sprite_x/y, i_flip: requested placement, captured on i_frame_tick
//   i_anim_en           : advance the hold counter on ticks
//   i_one_shot          : 0 = loop frames, 1 = stop on the last frame
//   i_restart           : back to frame 0 / PLAY, wins over a tick
//   o_sx/o_sy/o_flip    : latched placement used by the pixel pipeline
//   o_cur_frame         : current animation frame
//   o_anim_done         : one-shot sequence has reached its last frame
// ---------------------------------------------------------------------------
module sprite_anim_ctrl
    import sprite_pkg::*;
#(
    parameter int FRAMES = 2,
    parameter int HOLD   = 8,
    parameter int FW     = $clog2(FRAMES) + 1
) (
    input  logic          vga_clk,
    input  logic          reset_n,
    input  logic          i_frame_tick,
    input  logic [9:0]    i_sprite_x,
    input  logic [9:0]    i_sprite_y,
    input  logic          i_flip,
    input  logic          i_anim_en,
    input  logic          i_one_shot,
    input  logic          i_restart,
    output logic [9:0]    o_sx,
    output logic [9:0]    o_sy,
    output logic          o_flip,
    output logic [FW-1:0] o_cur_frame,
    output logic          o_anim_done
);

    localparam int CW = $clog2(HOLD) + 1;
    localparam logic [CW-1:0] HOLD_MAX   = CW'(HOLD - 1);
    localparam logic [FW-1:0] LAST_FRAME = FW'(FRAMES - 1);

    anim_state_t   r_state;
    logic [CW-1:0] r_hold_cnt;
    logic [FW-1:0] r_frame;
    logic          r_done;
    logic [FW-1:0] w_next_frame;

    // Loop mode wraps to 0; one-shot mode saturates on the last frame.
    assign w_next_frame = (r_frame != LAST_FRAME) ? r_frame + FW'(1) :
                          (i_one_shot ? LAST_FRAME : '0);

    // Positions only move at a frame boundary, so the sprite never tears.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            o_sx   <= '0;
            o_sy   <= '0;
            o_flip <= 1'b0;
        end else if (i_frame_tick) begin
            o_sx   <= i_sprite_x;
            o_sy   <= i_sprite_y;
            o_flip <= i_flip;
        end
    end

    // NOTE: state registers use non-blocking assignments so every read in
    // this block sees the value from before the clock edge.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= PLAY;
            r_hold_cnt <= '0;
            r_frame    <= '0;
            r_done     <= 1'b0;
        end else if (i_restart) begin
            r_state    <= PLAY;
            r_hold_cnt <= '0;
            r_frame    <= '0;
            r_done     <= 1'b0;
        end else if (i_frame_tick && i_anim_en && r_state == PLAY) begin
            if (r_hold_cnt != HOLD_MAX) begin
                r_hold_cnt <= r_hold_cnt + CW'(1);
            end else begin
                r_hold_cnt <= '0;
                r_frame    <= w_next_frame;
                if (i_one_shot && w_next_frame == LAST_FRAME) begin
                    r_state <= HOLD_LAST;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign o_cur_frame = r_frame;
    assign o_anim_done = r_done;

endmodule

// File: rtl/sprite_anim_renderer.sv
// ---------------------------------------------------------------------------
// sprite_anim_renderer
// Places one animated, scaled, optionally mirrored sprite on the VGA raster
// and emits a palette index plus hit flag, 2 vga_clk after DrawX/DrawY/blank.
//   vga_clk, reset_n      : pixel clock, async active-low reset
//   DrawX, DrawY, blank   : scan position, blank=1 during active video
//   frame_tick            : per-frame pulse (start of vertical blank)
//   sprite_x/y, flip_h    : placement, applied from the next frame
//   anim_en/one_shot/restart : animation control
//   rom_address / rom_q   : external synchronous sprite ROM (1-cycle read)
//   pixel_hit, pixel_idx  : opaque sprite pixel and its palette index
//   cur_frame, anim_done  : animation status
// Pipeline: stage 1 registers the ROM address and box flag; the ROM's own
// output register is stage 2, so hit/idx are gated from rom_q by the stage-2
// valid, which keeps them at 0 whenever reset is asserted.
// ---------------------------------------------------------------------------
module sprite_anim_renderer
    import sprite_pkg::*;
#(
    parameter int SPR_W      = 16,
    parameter int SPR_H      = 16,
    parameter int FRAMES     = 2,
    parameter int IDX_W      = 2,
    parameter int SCALE_LOG2 = 1,
    parameter int HOLD       = 8,
    parameter int TRANSP_IDX = 0,
    parameter int AW         = $clog2(SPR_W * SPR_H * FRAMES)
) (
    input  logic                     vga_clk,
    input  logic                     reset_n,
    input  logic [9:0]               DrawX,
    input  logic [9:0]               DrawY,
    input  logic                     blank,
    input  logic                     frame_tick,
    input  logic [9:0]               sprite_x,
    input  logic [9:0]               sprite_y,
    input  logic                     flip_h,
    input  logic                     anim_en,
    input  logic                     one_shot,
    input  logic                     restart,
    output logic [AW-1:0]            rom_address,
    input  logic [IDX_W-1:0]         rom_q,
    output logic                     pixel_hit,
    output logic [IDX_W-1:0]         pixel_idx,
    output logic [$clog2(FRAMES):0]  cur_frame,
    output logic                     anim_done
);

    localparam int FW = $clog2(FRAMES) + 1;
    localparam logic [10:0]      BOX_W  = 11'(SPR_W << SCALE_LOG2);
    localparam logic [10:0]      BOX_H  = 11'(SPR_H << SCALE_LOG2);
    localparam logic [IDX_W-1:0] TRANSP = IDX_W'(TRANSP_IDX);

    logic [9:0]    w_sx;
    logic [9:0]    w_sy;
    logic          w_flip;
    logic [FW-1:0] w_frame;

    sprite_anim_ctrl #(
        .FRAMES (FRAMES),
        .HOLD   (HOLD),
        .FW     (FW)
    ) u_ctrl (
        .vga_clk      (vga_clk),
        .reset_n      (reset_n),
        .i_frame_tick (frame_tick),
        .i_sprite_x   (sprite_x),
        .i_sprite_y   (sprite_y),
        .i_flip       (flip_h),
        .i_anim_en    (anim_en),
        .i_one_shot   (one_shot),
        .i_restart    (restart),
        .o_sx         (w_sx),
        .o_sy         (w_sy),
        .o_flip       (w_flip),
        .o_cur_frame  (w_frame),
        .o_anim_done  (anim_done)
    );

    assign cur_frame = w_frame;

    // Stage 0: 11-bit compares so a sprite hanging off the right/bottom
    // edge is clipped instead of wrapping back to column/row 0.
    logic [10:0]   w_lx;
    logic [10:0]   w_ly;
    logic [10:0]   w_col_raw;
    logic [10:0]   w_col;
    logic [10:0]   w_row;
    logic          w_in_box;
    logic [AW-1:0] w_addr;

    assign w_lx      = {1'b0, DrawX} - {1'b0, w_sx};
    assign w_ly      = {1'b0, DrawY} - {1'b0, w_sy};
    assign w_in_box  = blank
                     & ({1'b0, DrawX} >= {1'b0, w_sx}) & (w_lx < BOX_W)
                     & ({1'b0, DrawY} >= {1'b0, w_sy}) & (w_ly < BOX_H);
    assign w_col_raw = w_lx >> SCALE_LOG2;
    assign w_col     = w_flip ? 11'(SPR_W - 1) - w_col_raw : w_col_raw;
    assign w_row     = w_ly >> SCALE_LOG2;
    assign w_addr    = AW'(sprite_addr(32'(w_frame), 32'(w_row), 32'(w_col),
                                       SPR_W, SPR_H));

    logic r_in_box_d;
    logic r_in_box_d2;

    // Outside the box the address is held, so the ROM sees no needless toggling.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_address <= '0;
            r_in_box_d  <= 1'b0;
            r_in_box_d2 <= 1'b0;
        end else begin
            if (w_in_box)
                rom_address <= w_addr;
            r_in_box_d  <= w_in_box;
            r_in_box_d2 <= r_in_box_d;
        end
    end

    assign pixel_hit = r_in_box_d2 & (rom_q != TRANSP);
    assign pixel_idx = pixel_hit ? rom_q : '0;

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// ---------------------------------------------------------------------------
// tb_sprite_anim_renderer
// Directed bench for sprite_anim_renderer with default parameters
// (16x16 sprite, 2 frames, scale x2, HOLD=8, transparent index 0).
// ROM contents: address 5 holds 0, every other address a holds (a % 3) + 1.
// ---------------------------------------------------------------------------
module tb_sprite_anim_renderer;

    logic       vga_clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [9:0] DrawX = '0;
    logic [9:0] DrawY = '0;
    logic       blank = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] sprite_x = '0;
    logic [9:0] sprite_y = '0;
    logic       flip_h = 1'b0;
    logic       anim_en = 1'b0;
    logic       one_shot = 1'b0;
    logic       restart = 1'b0;
    logic [8:0] rom_address;
    logic [1:0] rom_q = '0;
    logic       pixel_hit;
    logic [1:0] pixel_idx;
    logic [1:0] cur_frame;
    logic       anim_done;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 vga_clk = ~vga_clk;

    sprite_anim_renderer dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .frame_tick  (frame_tick),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .flip_h      (flip_h),
        .anim_en     (anim_en),
        .one_shot    (one_shot),
        .restart     (restart),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .pixel_hit   (pixel_hit),
        .pixel_idx   (pixel_idx),
        .cur_frame   (cur_frame),
        .anim_done   (anim_done)
    );

    function automatic logic [1:0] rom_val(input logic [8:0] a);
        if (a == 9'd5)
            return 2'd0;
        return 2'((a % 9'd3) + 9'd1);
    endfunction

    always @(posedge vga_clk) rom_q <= rom_val(rom_address);

    typedef struct {
        string name;
        int    dx;
        int    dy;
        bit    blank;
        bit    chk_addr;
        int    exp_addr;
        bit    exp_hit;
        int    exp_idx;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic add_vec(input string n, input int dx, input int dy,
                           input bit bl, input bit ca, input int ea,
                           input bit eh, input int ei);
        vec_t v;
        v.name = n; v.dx = dx; v.dy = dy; v.blank = bl;
        v.chk_addr = ca; v.exp_addr = ea; v.exp_hit = eh; v.exp_idx = ei;
        vq.push_back(v);
    endtask

    // Each vector is held for two clocks: address after one, hit/idx after two.
    task automatic run_vecs();
        foreach (vq[i]) begin
            DrawX = 10'(vq[i].dx);
            DrawY = 10'(vq[i].dy);
            blank = vq[i].blank;
            @(posedge vga_clk); #1;
            if (vq[i].chk_addr)
                check({vq[i].name, " addr"}, 32'(rom_address), vq[i].exp_addr);
            @(posedge vga_clk); #1;
            check({vq[i].name, " hit"}, 32'(pixel_hit), 32'(vq[i].exp_hit));
            check({vq[i].name, " idx"}, 32'(pixel_idx), vq[i].exp_idx);
        end
        vq.delete();
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(posedge vga_clk); #1;
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge vga_clk); #1;
        restart = 1'b0;
    endtask

    initial begin
        // Reset state
        #2 reset_n = 1'b0;
        #1;
        check("reset hit", 32'(pixel_hit), 0);
        check("reset idx", 32'(pixel_idx), 0);
        check("reset addr", 32'(rom_address), 0);
        check("reset frame", 32'(cur_frame), 0);
        check("reset done", 32'(anim_done), 0);
        repeat (3) @(posedge vga_clk);
        #1 reset_n = 1'b1;

        // Basic placement at (100,50), scale 2, frame 0
        sprite_x = 10'd100; sprite_y = 10'd50;
        tick();
        add_vec("left of box",   99,  50, 1, 0,   0, 0, 0);
        add_vec("top-left",     100,  50, 1, 1,   0, 1, 1);
        add_vec("same texel",   101,  50, 1, 1,   0, 1, 1);
        add_vec("right col",    131,  50, 1, 1,  15, 1, 1);
        add_vec("past right",   132,  50, 1, 1,  15, 0, 0);
        add_vec("transparent",  110,  50, 1, 1,   5, 0, 0);
        add_vec("neighbour",    108,  50, 1, 1,   4, 1, 2);
        add_vec("row 1",        100,  52, 1, 1,  16, 1, 2);
        add_vec("bottom-right", 131,  81, 1, 1, 255, 1, 1);
        add_vec("past bottom",  131,  82, 1, 1, 255, 0, 0);
        add_vec("blanked",      100,  50, 0, 1, 255, 0, 0);
        run_vecs();

        // Horizontal flip, latched on a tick
        flip_h = 1'b1;
        tick();
        add_vec("flip left",    100,  50, 1, 1,  15, 1, 1);
        add_vec("flip right",   131,  50, 1, 1,   0, 1, 1);
        add_vec("flip transp",  121,  50, 1, 1,   5, 0, 0);
        run_vecs();
        flip_h = 1'b0;
        tick();

        // Loop animation
        check("anim_en=0 frame", 32'(cur_frame), 0);
        anim_en = 1'b1; one_shot = 1'b0;
        pulse_restart();
        ticks(7);
        check("loop tick7 frame", 32'(cur_frame), 0);
        tick();
        check("loop tick8 frame", 32'(cur_frame), 1);
        anim_en = 1'b0;
        add_vec("frame1 origin", 100, 50, 1, 1, 256, 1, 2);
        run_vecs();
        anim_en = 1'b1;
        ticks(7);
        check("loop tick15 frame", 32'(cur_frame), 1);
        tick();
        check("loop tick16 frame", 32'(cur_frame), 0);
        check("loop done", 32'(anim_done), 0);

        // One-shot
        pulse_restart();
        one_shot = 1'b1;
        ticks(7);
        check("oneshot tick7 done", 32'(anim_done), 0);
        tick();
        check("oneshot tick8 frame", 32'(cur_frame), 1);
        check("oneshot tick8 done", 32'(anim_done), 1);
        ticks(20);
        check("oneshot +20 frame", 32'(cur_frame), 1);
        check("oneshot +20 done", 32'(anim_done), 1);

        // Restart coincident with a tick; the shadow latch still loads
        sprite_x = 10'd630; sprite_y = 10'd470;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        anim_en = 1'b0;
        check("restart frame", 32'(cur_frame), 0);
        check("restart done", 32'(anim_done), 0);

        // Sprite hanging off the bottom-right corner
        add_vec("edge origin",  630, 470, 1, 1,  0, 1, 1);
        add_vec("edge last",    639, 479, 1, 1, 68, 1, 3);
        add_vec("edge x=0",       0, 470, 1, 0,  0, 0, 0);
        add_vec("edge y=0",     639,   0, 1, 0,  0, 0, 0);
        add_vec("edge left",    629, 470, 1, 0,  0, 0, 0);
        run_vecs();

        // Mid-frame request change without a tick
        sprite_x = 10'd100; sprite_y = 10'd50;
        add_vec("no tear old",  630, 470, 1, 1,  0, 1, 1);
        add_vec("no tear new",  100,  50, 1, 0,  0, 0, 0);
        run_vecs();

        // Reset asserted mid-line, then recovery
        DrawX = 10'd630; DrawY = 10'd470; blank = 1'b1;
        @(posedge vga_clk); #1;
        @(posedge vga_clk); #1;
        check("pre-reset hit", 32'(pixel_hit), 1);
        #2 reset_n = 1'b0;
        #1;
        check("async reset hit", 32'(pixel_hit), 0);
        check("async reset idx", 32'(pixel_idx), 0);
        check("async reset addr", 32'(rom_address), 0);
        @(posedge vga_clk); #1;
        DrawX = 10'd0; DrawY = 10'd0;
        reset_n = 1'b1;
        @(posedge vga_clk); #1;
        check("post-reset cyc1 hit", 32'(pixel_hit), 0);
        @(posedge vga_clk); #1;
        check("post-reset cyc2 hit", 32'(pixel_hit), 1);
        check("post-reset cyc2 idx", 32'(pixel_idx), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
